// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Definitions shared by the NoC router blocks (input buffers, arbiter, crossbar):
// flit type codes, the flit_id field width (the field sits at the top of the
// flit), the packet length width, router port indices, the input-buffer packet
// state type and small flit-type helpers.
// -----------------------------------------------------------------------------
package noc_pkg;

    localparam int FID_W = 3;   // flit_id occupies flit[FLIT_W-1 -: FID_W]
    localparam int LEN_W = 12;  // packet length carried in header payload[11:0]

    localparam logic [FID_W-1:0] FLIT_HEADER = 3'b001;
    localparam logic [FID_W-1:0] FLIT_BODY   = 3'b010;
    localparam logic [FID_W-1:0] FLIT_TAIL   = 3'b100;

    localparam int PORT_L = 0;
    localparam int PORT_N = 1;
    localparam int PORT_E = 2;
    localparam int PORT_W = 3;
    localparam int PORT_S = 4;

    typedef enum logic {
        PKT_IDLE   = 1'b0,
        PKT_ACTIVE = 1'b1
    } pkt_state_e;

    // Unknown codes are not headers or tails, so they behave as BODY.
    function automatic logic is_header(input logic [FID_W-1:0] id);
        return id == FLIT_HEADER;
    endfunction

    function automatic logic is_tail(input logic [FID_W-1:0] id);
        return id == FLIT_TAIL;
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// -----------------------------------------------------------------------------
// noc_sync_fifo
// Single-clock circular flit FIFO with a combinational head read.
// Ports:
//   clk, rst   clock, synchronous active-high reset (pointers/count only)
//   push       write push_flit (ignored when full)
//   push_flit  flit to write
//   pop        drop the head entry (ignored when empty)
//   full/empty occupancy flags
//   count      occupancy 0..DEPTH
//   head       entry at the read pointer
// -----------------------------------------------------------------------------
module noc_sync_fifo #(
    parameter int DEPTH  = 8,
    parameter int FLIT_W = 32,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [FLIT_W-1:0] push_flit,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [PTR_W:0]    count,
    output logic [FLIT_W-1:0] head
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              do_push, do_pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        // DEPTH is a power of two, so pointers wrap naturally.
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_flit;
        end
    end

endmodule

// File: rtl/noc_input_buffer.sv
// -----------------------------------------------------------------------------
// noc_input_buffer
// Per-port router input stage: buffers flits, tracks packet framing and
// presents the head-of-line packet to the arbiter, forwarding flits to the
// crossbar while this port holds the grant.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_flit    upstream flit; in_ready = buffer not full
//   req/flit_id/length  arbiter request, head flit type, latched packet length
//   grant               arbiter grant bit for this port
//   out_valid/out_flit  flit toward crossbar; out_ready = downstream accepts
//   drop_err            one-cycle pulse on a discarded stray flit or a header
//                       forwarded in place of a missing tail
//   count               buffer occupancy
// -----------------------------------------------------------------------------
module noc_input_buffer
    import noc_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int FLIT_W = 32,
    parameter int PTR_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [FLIT_W-1:0] in_flit,
    output logic              in_ready,
    output logic              req,
    output logic [2:0]        flit_id,
    output logic [11:0]       length,
    input  logic              grant,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [FLIT_W-1:0] out_flit,
    output logic              drop_err,
    output logic [PTR_W:0]    count
);

    logic              fifo_full, fifo_empty, fifo_pop;
    logic [FLIT_W-1:0] head;
    logic [FID_W-1:0]  head_id;

    pkt_state_e       state_q, state_d;
    logic [LEN_W-1:0] length_q, length_d;
    logic             first_q, first_d;     // packet's own header not yet popped
    logic             drop_err_q, drop_err_d;
    logic             out_valid_c;

    noc_sync_fifo #(
        .DEPTH  (DEPTH),
        .FLIT_W (FLIT_W),
        .PTR_W  (PTR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid && !fifo_full),
        .push_flit (in_flit),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count),
        .head      (head)
    );

    assign head_id   = head[FLIT_W-1 -: FID_W];
    assign in_ready  = !fifo_full;
    assign flit_id   = fifo_empty ? 3'b000 : head_id;
    assign out_flit  = head;
    assign out_valid = out_valid_c;
    assign req       = (state_q == PKT_ACTIVE);
    assign length    = length_q;
    assign drop_err  = drop_err_q;

    always_comb begin
        state_d     = state_q;
        length_d    = length_q;
        first_d     = first_q;
        drop_err_d  = 1'b0;
        fifo_pop    = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            PKT_IDLE: begin
                if (!fifo_empty) begin
                    if (is_header(head_id)) begin
                        // Header stays in the FIFO; it is the first flit sent.
                        length_d = head[LEN_W-1:0];
                        first_d  = 1'b1;
                        state_d  = PKT_ACTIVE;
                    end else begin
                        fifo_pop   = 1'b1;
                        drop_err_d = 1'b1;
                    end
                end
            end
            PKT_ACTIVE: begin
                // Combinational so a revoked grant stops transfer immediately.
                out_valid_c = grant && !fifo_empty;
                if (out_valid_c && out_ready) begin
                    fifo_pop = 1'b1;
                    first_d  = 1'b0;
                    if (is_tail(head_id)) begin
                        state_d = PKT_IDLE;
                    end else if (is_header(head_id) && !first_q) begin
                        // Next packet started without a tail: keep going as
                        // one stream but flag it and adopt the new length.
                        drop_err_d = 1'b1;
                        length_d   = head[LEN_W-1:0];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= PKT_IDLE;
            length_q   <= '0;
            first_q    <= 1'b0;
            drop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            length_q   <= length_d;
            first_q    <= first_d;
            drop_err_q <= drop_err_d;
        end
    end

endmodule

// File: tb/tb_noc_input_buffer.sv
// -----------------------------------------------------------------------------
// tb_noc_input_buffer
// Directed bench for noc_input_buffer. Flits expected at the crossbar side are
// queued when issued; a monitor compares each accepted output flit in order.
// -----------------------------------------------------------------------------
module tb_noc_input_buffer;
    import noc_pkg::*;

    localparam int DEPTH  = 8;
    localparam int FLIT_W = 32;
    localparam int PTR_W  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [FLIT_W-1:0] in_flit;
    logic              in_ready;
    logic              req;
    logic [2:0]        flit_id;
    logic [11:0]       length;
    logic              grant;
    logic              out_ready;
    logic              out_valid;
    logic [FLIT_W-1:0] out_flit;
    logic              drop_err;
    logic [PTR_W:0]    count;

    int checks = 0;
    int errors = 0;
    logic [FLIT_W-1:0] exp_q[$];

    noc_input_buffer #(.DEPTH(DEPTH), .FLIT_W(FLIT_W), .PTR_W(PTR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_flit   (in_flit),
        .in_ready  (in_ready),
        .req       (req),
        .flit_id   (flit_id),
        .length    (length),
        .grant     (grant),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_flit  (out_flit),
        .drop_err  (drop_err),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic logic [FLIT_W-1:0] mk(input logic [2:0] id, input logic [28:0] pl);
        return {id, pl};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle push; fwd says whether the flit should later reach the output.
    task automatic push(input logic [FLIT_W-1:0] f, input bit fwd);
        in_valid = 1'b1;
        in_flit  = f;
        if (fwd) exp_q.push_back(f);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (count == 0 && !req && !out_valid) done = 1'b1;
            else tick();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: drain timeout, count=%0d req=%0b expected count=0 req=0", nm, count, req);
        end
    endtask

    // Scoreboard monitor: a transfer happens at the next posedge.
    always @(negedge clk) begin
        logic [FLIT_W-1:0] e;
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_flit: got %h expected none", out_flit);
            end else begin
                e = exp_q.pop_front();
                if (out_flit !== e) begin
                    errors++;
                    $display("FAIL out_flit: got %h expected %h", out_flit, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_flit = '0; grant = 1'b0; out_ready = 1'b1;
        tick(); tick();
        // Reset state
        chk("rst_count", 32'(count), 0);
        chk("rst_req", 32'(req), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_drop_err", 32'(drop_err), 0);
        chk("rst_length", 32'(length), 0);
        rst = 1'b0;

        // Packet buffered without grant
        push(mk(FLIT_HEADER, 29'h005), 1'b1);
        chk("t1_req_before", 32'(req), 0);
        chk("t1_flit_id", 32'(flit_id), 1);
        push(mk(FLIT_BODY, 29'h111), 1'b1);
        chk("t1_req_rise", 32'(req), 1);
        push(mk(FLIT_BODY, 29'h222), 1'b1);
        push(mk(FLIT_TAIL, 29'h333), 1'b1);
        chk("t1_count", 32'(count), 4);
        chk("t1_length", 32'(length), 'h005);
        chk("t1_flit_id2", 32'(flit_id), 1);
        chk("t1_out_valid", 32'(out_valid), 0);

        // Granted: four flits on consecutive cycles
        grant = 1'b1;
        tick(); tick(); tick();
        chk("t2_req_mid", 32'(req), 1);
        chk("t2_count_mid", 32'(count), 1);
        tick();
        chk("t2_count_end", 32'(count), 0);
        chk("t2_req_fall", 32'(req), 0);
        grant = 1'b0;

        // Fill to DEPTH, ninth push ignored
        push(mk(FLIT_HEADER, 29'h006), 1'b1);
        for (int i = 0; i < 6; i++) push(mk(FLIT_BODY, 29'(i + 'h40)), 1'b1);
        push(mk(FLIT_TAIL, 29'h04F), 1'b1);
        chk("t3_count_full", 32'(count), 8);
        chk("t3_in_ready_full", 32'(in_ready), 0);
        push(mk(FLIT_BODY, 29'hBAD), 1'b0);
        chk("t3_count_ignored", 32'(count), 8);
        grant = 1'b1;
        tick();
        chk("t3_count_pop", 32'(count), 7);
        push(mk(FLIT_HEADER, 29'h003), 1'b1);
        chk("t3_count_pp0", 32'(count), 7);
        push(mk(FLIT_BODY, 29'h050), 1'b1);
        chk("t3_count_pp1", 32'(count), 7);
        push(mk(FLIT_BODY, 29'h051), 1'b1);
        chk("t3_count_pp2", 32'(count), 7);
        push(mk(FLIT_TAIL, 29'h052), 1'b1);
        chk("t3_count_pp3", 32'(count), 7);
        wait_drain("t3_drain");
        grant = 1'b0;

        // Grant revoked mid-packet
        push(mk(FLIT_HEADER, 29'h004), 1'b1);
        push(mk(FLIT_BODY, 29'h061), 1'b1);
        push(mk(FLIT_BODY, 29'h062), 1'b1);
        push(mk(FLIT_TAIL, 29'h063), 1'b1);
        grant = 1'b1;
        tick(); tick();
        grant = 1'b0;
        #1;
        chk("t4_out_valid_drop", 32'(out_valid), 0);
        chk("t4_req_hold", 32'(req), 1);
        tick(); tick(); tick();
        chk("t4_count_hold", 32'(count), 2);
        chk("t4_req_hold2", 32'(req), 1);
        grant = 1'b1;
        tick(); tick();
        chk("t4_count_end", 32'(count), 0);
        chk("t4_req_end", 32'(req), 0);
        grant = 1'b0;

        // Stray body flit in IDLE
        push(mk(FLIT_BODY, 29'h077), 1'b0);
        chk("t5_count_stray", 32'(count), 1);
        chk("t5_drop_before", 32'(drop_err), 0);
        tick();
        chk("t5_drop_pulse", 32'(drop_err), 1);
        chk("t5_count_dropped", 32'(count), 0);
        chk("t5_req_low", 32'(req), 0);
        tick();
        chk("t5_drop_end", 32'(drop_err), 0);
        grant = 1'b1;
        push(mk(FLIT_HEADER, 29'h009), 1'b1);
        push(mk(FLIT_TAIL, 29'h078), 1'b1);
        chk("t5_length", 32'(length), 'h009);
        wait_drain("t5_drain");
        chk("t5_drop_quiet", 32'(drop_err), 0);
        grant = 1'b0;

        // Header arriving in place of a tail
        push(mk(FLIT_HEADER, 29'h001), 1'b1);
        push(mk(FLIT_BODY, 29'h081), 1'b1);
        push(mk(FLIT_HEADER, 29'h007), 1'b1);
        push(mk(FLIT_TAIL, 29'h083), 1'b1);
        grant = 1'b1;
        tick(); tick(); tick();
        chk("t6_drop_pulse", 32'(drop_err), 1);
        chk("t6_length_relatch", 32'(length), 'h007);
        chk("t6_req_hold", 32'(req), 1);
        tick();
        chk("t6_drop_end", 32'(drop_err), 0);
        chk("t6_req_fall", 32'(req), 0);
        chk("t6_count", 32'(count), 0);
        grant = 1'b0;

        // Reset mid-packet
        push(mk(FLIT_HEADER, 29'h00A), 1'b0);
        push(mk(FLIT_BODY, 29'h091), 1'b0);
        push(mk(FLIT_BODY, 29'h092), 1'b0);
        chk("t7_count_pre", 32'(count), 3);
        chk("t7_req_pre", 32'(req), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t7_count", 32'(count), 0);
        chk("t7_req", 32'(req), 0);
        chk("t7_out_valid", 32'(out_valid), 0);
        chk("t7_in_ready", 32'(in_ready), 1);
        grant = 1'b1;
        push(mk(FLIT_HEADER, 29'h002), 1'b1);
        push(mk(FLIT_TAIL, 29'h0A1), 1'b1);
        wait_drain("t7_drain");
        chk("t7_length", 32'(length), 'h002);
        grant = 1'b0;

        tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
